// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and the fetch queue entry type
package fetch_pkg;

    localparam int INSTR_W     = 32;
    localparam int ADDR_W      = 64;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular queue of fetched {pc, instr} entries
// Ports: clk, rst_n (async, active low); flush empties the queue;
//        push/push_data write the tail; pop advances the head;
//        head is the registered head entry; full/empty status.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t      mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    assign head  = mem[rd_ptr];
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter, fetch control and decode-side queue
// Ports: clk, rst_n (async, active low); imem_adr/imem_instr to instruction
//        memory; fetch_en gates fetch; redirect_valid/redirect_pc retarget;
//        out_valid/out_ready/out_instr/out_pc to decode;
//        misalign_err pulse on unaligned redirect; end_of_mem level.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PC_RESET   = 64'h0,
    parameter logic [ADDR_W-1:0] IMEM_BYTES = 64'd64,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_adr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               misalign_err,
    output logic               end_of_mem
);

    logic [ADDR_W-1:0] pc;
    logic              deq;
    logic              enq;
    logic              fifo_full;
    logic              fifo_empty;
    fetch_entry_t      fifo_head;
    fetch_entry_t      fifo_in;

    assign imem_adr = pc;

    // One extra bit keeps the compare honest near the top of the address space.
    assign end_of_mem = ({1'b0, pc} + 65'd3) >= {1'b0, IMEM_BYTES};

    assign out_valid = !fifo_empty;
    assign deq       = out_valid & out_ready;
    // A full queue can still accept when its head leaves in the same cycle.
    assign enq       = fetch_en & !end_of_mem & !redirect_valid & (!fifo_full | deq);

    assign fifo_in.pc    = pc;
    assign fifo_in.instr = imem_instr;

    assign out_instr = fifo_head.instr;
    assign out_pc    = fifo_head.pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (enq),
        .push_data (fifo_in),
        .pop       (deq & !redirect_valid),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= PC_RESET;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid & (|redirect_pc[1:0]);
            if (redirect_valid) begin
                pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (enq) begin
                pc <= pc + ADDR_W'(INSTR_BYTES);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [63:0] imem_adr;
    logic [31:0] imem_instr;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        misalign_err;
    logic        end_of_mem;

    logic [63:0] imem_adr2;
    logic [31:0] imem_instr2;
    logic        fetch_en2 = 1'b0;
    logic        redirect_valid2 = 1'b0;
    logic [63:0] redirect_pc2 = '0;
    logic        out_valid2;
    logic [31:0] out_instr2;
    logic [63:0] out_pc2;
    logic        misalign_err2;
    logic        end_of_mem2;

    logic [31:0] mem_words [16];
    logic [95:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          delivered2 = 0;

    always #5 clk = ~clk;

    initial begin
        mem_words[0] = 32'h8B1F03E5;
        mem_words[1] = 32'hF84000A4;
        mem_words[2] = 32'h8B040086;
        mem_words[3] = 32'hF80010A6;
        for (int i = 4; i < 16; i++) mem_words[i] = 32'hA000_0000 | i;
    end

    assign imem_instr  = mem_words[imem_adr[5:2]];
    assign imem_instr2 = mem_words[imem_adr2[5:2]];

    instr_fetch_unit u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_adr       (imem_adr),
        .imem_instr     (imem_instr),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err),
        .end_of_mem     (end_of_mem)
    );

    instr_fetch_unit #(.IMEM_BYTES(64'd16)) u_dut16 (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_adr       (imem_adr2),
        .imem_instr     (imem_instr2),
        .fetch_en       (fetch_en2),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2),
        .out_valid      (out_valid2),
        .out_ready      (1'b1),
        .out_instr      (out_instr2),
        .out_pc         (out_pc2),
        .misalign_err   (misalign_err2),
        .end_of_mem     (end_of_mem2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        fetch_en = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor for the main instance: every accepted head must match.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got pc %h instr %h expected none", out_pc, out_instr);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                if ({out_pc, out_instr} !== e) begin
                    errors++;
                    $display("FAIL sb_out: got pc %h instr %h expected pc %h instr %h",
                             out_pc, out_instr, e[95:32], e[31:0]);
                end
            end
        end
    end

    // Monitor for the 16-byte instance: deliveries must be 0,4,8,... in order.
    always @(negedge clk) begin
        if (rst_n && out_valid2) begin
            checks++;
            if (out_pc2 !== 64'(delivered2 * 4) || out_instr2 !== mem_words[delivered2[3:0]]) begin
                errors++;
                $display("FAIL mem16_out: got pc %h instr %h expected pc %h", out_pc2, out_instr2,
                         64'(delivered2 * 4));
            end
            delivered2++;
        end
    end

    initial begin
        // Reset state
        do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_pc", imem_adr, 64'd0);
        chk("rst_misalign", {63'd0, misalign_err}, 64'd0);
        chk("rst_end_of_mem", {63'd0, end_of_mem}, 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", {32'd0, out_instr}, 64'd0);

        // Streaming: four words on consecutive cycles
        do_reset();
        exp_q.push_back({64'd0,  32'h8B1F03E5});
        exp_q.push_back({64'd4,  32'hF84000A4});
        exp_q.push_back({64'd8,  32'h8B040086});
        exp_q.push_back({64'd12, 32'hF80010A6});
        fetch_en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
            chk("stream_pc", out_pc, 64'(i * 4));
        end
        fetch_en = 1'b0;
        tick();
        chk("stream_drained", {63'd0, out_valid}, 64'd0);
        chk("stream_pc_next", imem_adr, 64'd16);

        // Backpressure: queue saturates, pc stops at 16, then drains in order
        do_reset();
        fetch_en = 1'b1;
        repeat (6) tick();
        chk("bp_pc_hold", imem_adr, 64'd16);
        chk("bp_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_head_pc", out_pc, 64'd0);
        chk("bp_head_instr", {32'd0, out_instr}, 64'h8B1F03E5);
        for (int i = 0; i < 4; i++) exp_q.push_back({64'(i * 4), mem_words[i]});
        fetch_en = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("bp_empty", {63'd0, out_valid}, 64'd0);
        chk("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        // Aligned redirect with 3 entries queued
        do_reset();
        fetch_en = 1'b1;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'd8;
        tick();
        redirect_valid = 1'b0;
        chk("redir_flush", {63'd0, out_valid}, 64'd0);
        chk("redir_misalign", {63'd0, misalign_err}, 64'd0);
        chk("redir_pc", imem_adr, 64'd8);
        exp_q.push_back({64'd8, 32'h8B040086});
        out_ready = 1'b1;
        tick();
        fetch_en = 1'b0;
        chk("redir_first_pc", out_pc, 64'd8);
        chk("redir_first_instr", {32'd0, out_instr}, 64'h8B040086);
        tick();
        chk("redir_done", {63'd0, out_valid}, 64'd0);

        // Misaligned redirect: one-cycle error pulse, fetch from aligned address
        redirect_valid = 1'b1;
        redirect_pc = 64'h6;
        fetch_en = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("mis_pulse", {63'd0, misalign_err}, 64'd1);
        chk("mis_flush", {63'd0, out_valid}, 64'd0);
        chk("mis_pc", imem_adr, 64'd4);
        exp_q.push_back({64'd4, 32'hF84000A4});
        tick();
        fetch_en = 1'b0;
        chk("mis_pulse_end", {63'd0, misalign_err}, 64'd0);
        chk("mis_valid", {63'd0, out_valid}, 64'd1);
        tick();

        // End of memory on the 16-byte instance
        fetch_en2 = 1'b1;
        repeat (8) tick();
        chk("eom_flag", {63'd0, end_of_mem2}, 64'd1);
        chk("eom_pc_hold", imem_adr2, 64'd16);
        chk("eom_delivered", 64'(delivered2), 64'd4);
        fetch_en2 = 1'b0;
        redirect_valid2 = 1'b1;
        redirect_pc2 = 64'd0;
        tick();
        redirect_valid2 = 1'b0;
        chk("eom_cleared", {63'd0, end_of_mem2}, 64'd0);
        chk("eom_redir_pc", imem_adr2, 64'd0);

        // Asynchronous reset mid-stream with 2 entries queued
        do_reset();
        fetch_en = 1'b1;
        repeat (2) tick();
        chk("ar_pre_pc", imem_adr, 64'd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_pc", imem_adr, 64'd0);
        chk("ar_out_pc", out_pc, 64'd0);
        tick();
        rst_n = 1'b1;
        fetch_en = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back({64'd0, 32'h8B1F03E5});
        tick();
        fetch_en = 1'b0;
        chk("ar_first_pc", out_pc, 64'd0);
        repeat (2) tick();
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch-side initiator for the byte-addressed instruction memory. Holds the program counter and drives the memory's 64-bit byte address. Captures the combinational 32-bit little-endian instruction word into a small FIFO, which feeds the decode stage over a valid/ready handshake. Supports branch redirect with FIFO flush, and stops cleanly at the end of memory.

Parameters:
PC_RESET, 64'h0, PC value loaded at reset; must be a multiple of 4
IMEM_BYTES, 64, instruction memory size in bytes; fetch is legal while pc + 3 < IMEM_BYTES
FIFO_DEPTH, 4, fetch queue entries; power of 2, minimum 2

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
imem_adr  out  64  byte address to instruction memory; always equals pc
imem_instr  in  32  combinational instruction word read at imem_adr
fetch_en  in  1  1 = fetch allowed this cycle
redirect_valid  in  1  1-cycle request to redirect fetch
redirect_pc  in  64  new fetch target
out_valid  out  1  FIFO head is valid
out_ready  in  1  decode accepts the head
out_instr  out  32  head instruction
out_pc  out  64  byte address the head was fetched from
misalign_err  out  1  registered 1-cycle pulse: redirect_pc[1:0] != 0
end_of_mem  out  1  level: pc is past the last legal word

Behaviour:
- Reset: the clock and reset are fixed as one clock, clk, with an asynchronous, active-low reset, rst_n.
  - Asserting rst_n low immediately sets pc=PC_RESET, empties the FIFO, and drives out_valid=0, misalign_err=0, end_of_mem=(PC_RESET+3 >= IMEM_BYTES).
  - out_instr and out_pc reset to 0.
  - Reset asserted mid-operation discards all queued entries.
- Dequeue (deq): deq = out_valid & out_ready.
- Enqueue (enq): enq = fetch_en & !end_of_mem & !redirect_valid & (count < FIFO_DEPTH | deq).
  - Enqueue is allowed when the FIFO is full only if a dequeue happens in the same cycle.
- On enq, at the clock edge: push {pc, imem_instr} and set pc <= pc + 4.
  - Fetch-to-out_valid latency is 1 cycle.
  - Sustained throughput is 1 instruction per cycle.
- Simultaneous enq and deq: count is unchanged, and head and tail pointers both advance.
- FIFO pointers wrap modulo FIFO_DEPTH.
  - Full when count == FIFO_DEPTH; empty when count == 0.
  - Pointers are log2(FIFO_DEPTH) bits wide; count is one bit wider.
- out_instr and out_pc come from the head entry, i.e. they are registered FIFO contents with no combinational path from imem_instr.
  - Both must hold stable while out_valid=1 and out_ready=0.
- Redirect has priority over everything except reset. At the edge:
  - FIFO is flushed (count=0) and any same-cycle deq is ignored.
  - pc <= {redirect_pc[63:2], 2'b00}.
  - misalign_err <= |redirect_pc[1:0]; it is 0 on every other cycle.
  - The next cycle out_valid=0; the first instruction from the new target appears one cycle after that, if enq is allowed.
- end_of_mem = (pc + 3 >= IMEM_BYTES), computed combinationally from pc.
  - While end_of_mem is 1 there is no enq, pc holds, and already-queued entries still drain.
  - A redirect back into range resumes fetch.
  - pc arithmetic is 64-bit unsigned; wrap at 2^64 is not special-cased because end_of_mem blocks fetch first.
- fetch_en=0 freezes pc; the FIFO still drains.
- Simultaneous redirect and fetch_en=0: the redirect still takes effect.

Decomposition:
- Package fetch_pkg holds:
  - INSTR_W=32, ADDR_W=64, INSTR_BYTES=4.
  - Typedef fetch_entry_t: struct {logic [63:0] pc; logic [31:0] instr;}.
- One sub-module is natural: fetch_fifo (parameterised depth, fetch_entry_t payload, push/pop/flush, full/empty/count).
- instr_fetch_unit contains the pc register, the enq/redirect control and the error/end flags.

Test Plan:
- Memory words at 0/4/8/12 = 0x8B1F03E5, 0xF84000A4, 0x8B040086, 0xF80010A6. Hold out_ready=1 and fetch_en=1 after reset -> out_valid rises in cycle 1; the four words stream on consecutive cycles with out_pc 0, 4, 8, 12.
- Hold out_ready=0 for 6 cycles -> count saturates at 4 and pc stops at 16. Release out_ready -> entries pc 0..12 drain in order with no loss and no duplicates.
- Issue redirect_valid with redirect_pc=8 while the FIFO holds 3 entries -> the next cycle out_valid=0 and misalign_err=0; then out_pc=8 with instr 0x8B040086.
- Issue redirect_pc=0x6 -> misalign_err pulses for exactly 1 cycle and fetch resumes at pc=4 with 0xF84000A4.
- With IMEM_BYTES=16, run freely -> after pc=12 is enqueued, end_of_mem=1 and pc holds at 16; exactly 4 entries are delivered. A redirect to 0 clears end_of_mem.
- Drop rst_n asynchronously mid-stream with 2 entries queued -> out_valid=0 and pc=PC_RESET immediately, without waiting for a clock edge; after release the first output is pc=0.
